icache_sa: RTL and testbench



---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_victim_sel.sv | 21 ++
 rtl/icache_sa.sv | 170 +++++++++++++++++
 tb/tb_icache_sa.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
package icache_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned ICACHE_SETS         = 16;
  localparam int unsigned ICACHE_WAYS         = 2;
  localparam int unsigned ICACHE_ADDR_BITS    = 16;
  localparam int unsigned ICACHE_MEM_TAG_BITS = 4;

  localparam int unsigned INDEX_BITS = $clog2(ICACHE_SETS);
  localparam int unsigned TAG_BITS   = ICACHE_ADDR_BITS - 3 - INDEX_BITS;

  // Stored tag field is sized for the smallest legal set count, so any SETS fits.
  localparam int unsigned LINE_TAG_BITS = XLEN - 4;

  localparam logic [1:0] BUS_NONE = 2'b00;
  localparam logic [1:0] BUS_LOAD = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } icache_state_e;

  typedef struct packed {
    logic [63:0]              data;
    logic [LINE_TAG_BITS-1:0] tag;
    logic                     valid;
  } icache_way_t;

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection: lowest-numbered invalid way, else the set's round-robin pointer.
module icache_victim_sel #(
  parameter  int unsigned WAYS  = 2,
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]  valid_i,
  input  logic [WAY_W-1:0] rr_ptr_i,
  output logic [WAY_W-1:0] victim_way_c_o,
  output logic             rr_used_c_o
);

  // Descending scan so the lowest invalid way wins.
  always_comb begin
    victim_way_c_o = rr_ptr_i;
    rr_used_c_o    = &valid_i;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (!valid_i[i]) victim_way_c_o = WAY_W'(i);
    end
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational hit lookup, miss FSM with retry,
// redirect-tolerant fill, invalidate-all and same-cycle fill bypass.
module icache_sa
  import icache_pkg::*;
#(
  parameter int unsigned SETS         = ICACHE_SETS,
  parameter int unsigned WAYS         = ICACHE_WAYS,
  parameter int unsigned ADDR_BITS    = ICACHE_ADDR_BITS,
  parameter int unsigned MEM_TAG_BITS = ICACHE_MEM_TAG_BITS
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [XLEN-1:0]         proc2Icache_addr,
  input  logic                    invalidate_all,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_response,
  input  logic [63:0]             Imem2proc_data,
  input  logic [MEM_TAG_BITS-1:0] Imem2proc_tag,
  output logic [1:0]              proc2Imem_command,
  output logic [XLEN-1:0]         proc2Imem_addr,
  output logic [63:0]             Icache_data_out,
  output logic                    Icache_valid_out,
  output logic                    miss_busy
);

  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_BITS - 3 - IDX_W;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned LINE_W = XLEN - 3;

  icache_state_e           state_q, state_d;
  logic [LINE_W-1:0]       miss_line_q, miss_line_d;
  logic [MEM_TAG_BITS-1:0] pend_tag_q, pend_tag_d;
  logic                    drop_fill_q, drop_fill_d;

  icache_way_t             lines_q [SETS][WAYS];
  logic [WAY_W-1:0]        rr_q    [SETS];

  logic [LINE_W-1:0]        fetch_line_c;
  logic [IDX_W-1:0]         fetch_idx_c, fill_idx_c;
  logic [LINE_TAG_BITS-1:0] fetch_tag_c, fill_tag_c;
  logic [WAYS-1:0]          hit_w;
  logic [63:0]              hit_data_c;
  logic [WAYS-1:0]          fill_valid_c;
  logic [WAY_W-1:0]         victim_c;
  logic                     rr_used_c;
  logic                     fill_hit_c, write_en_c, bypass_c;
  logic                     unused_offset;

  assign fetch_line_c  = proc2Icache_addr[XLEN-1:3];
  assign fetch_idx_c   = fetch_line_c[IDX_W-1:0];
  assign fetch_tag_c   = LINE_TAG_BITS'(fetch_line_c[IDX_W +: TAG_W]);
  assign fill_idx_c    = miss_line_q[IDX_W-1:0];
  assign fill_tag_c    = LINE_TAG_BITS'(miss_line_q[IDX_W +: TAG_W]);
  assign unused_offset = ^proc2Icache_addr[2:0];

  // Per-way hit vector and one-hot data mux for the fetch set.
  always_comb begin
    hit_w      = '0;
    hit_data_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (lines_q[fetch_idx_c][w].valid && (lines_q[fetch_idx_c][w].tag == fetch_tag_c)) begin
        hit_w[w]   = 1'b1;
        hit_data_c = hit_data_c | lines_q[fetch_idx_c][w].data;
      end
    end
  end

  always_comb begin
    fill_valid_c = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      fill_valid_c[w] = lines_q[fill_idx_c][w].valid;
    end
  end

  icache_victim_sel #(
    .WAYS (WAYS)
  ) u_victim_sel (
    .valid_i        (fill_valid_c),
    .rr_ptr_i       (rr_q[fill_idx_c]),
    .victim_way_c_o (victim_c),
    .rr_used_c_o    (rr_used_c)
  );

  assign fill_hit_c = (state_q == WAIT) && (pend_tag_q != '0) && (Imem2proc_tag == pend_tag_q);
  assign write_en_c = fill_hit_c && !drop_fill_q && !invalidate_all;
  assign bypass_c   = fill_hit_c && !drop_fill_q && (fetch_line_c == miss_line_q);

  assign Icache_valid_out = (|hit_w) || bypass_c;
  assign Icache_data_out  = (|hit_w) ? hit_data_c : Imem2proc_data;
  assign proc2Imem_addr   = {miss_line_q, 3'b000};
  assign miss_busy        = (state_q != IDLE);

  // Miss FSM: next state, captured miss context and bus command.
  always_comb begin
    state_d           = state_q;
    miss_line_d       = miss_line_q;
    pend_tag_d        = pend_tag_q;
    drop_fill_d       = drop_fill_q;
    proc2Imem_command = BUS_NONE;
    unique case (state_q)
      IDLE: begin
        if (!(|hit_w) && !invalidate_all) begin
          miss_line_d = fetch_line_c;
          state_d     = REQ;
        end
      end
      REQ: begin
        proc2Imem_command = BUS_LOAD;
        // An accepted request is always tracked, even on redirect or invalidate.
        if (Imem2proc_response != '0) begin
          pend_tag_d  = Imem2proc_response;
          drop_fill_d = invalidate_all;
          state_d     = WAIT;
        end else if (invalidate_all || (fetch_line_c != miss_line_q)) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (fill_hit_c) begin
          drop_fill_d = 1'b0;
          state_d     = IDLE;
        end else if (invalidate_all) begin
          drop_fill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      miss_line_q <= '0;
      pend_tag_q  <= '0;
      drop_fill_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_line_q <= miss_line_d;
      pend_tag_q  <= pend_tag_d;
      drop_fill_q <= drop_fill_d;
    end
  end

  // Line array: invalidate-all clears every valid bit, otherwise fills land in the victim way.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(SETS); s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < int'(WAYS); w++) begin
          lines_q[s][w] <= '0;
        end
      end
    end else if (invalidate_all) begin
      for (int s = 0; s < int'(SETS); s++) begin
        for (int w = 0; w < int'(WAYS); w++) begin
          lines_q[s][w].valid <= 1'b0;
        end
      end
    end else if (write_en_c) begin
      lines_q[fill_idx_c][victim_c].data  <= Imem2proc_data;
      lines_q[fill_idx_c][victim_c].tag   <= fill_tag_c;
      lines_q[fill_idx_c][victim_c].valid <= 1'b1;
      if (rr_used_c) begin
        rr_q[fill_idx_c] <= (rr_q[fill_idx_c] == WAY_W'(WAYS - 1)) ? '0
                                                                   : rr_q[fill_idx_c] + WAY_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed scenarios plus randomized traffic against
// a line-level behavioural model of the cache and its miss handling.
module tb_icache_sa;
  import icache_pkg::*;

  localparam int unsigned NS = ICACHE_SETS;
  localparam int unsigned NW = ICACHE_WAYS;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] proc2Icache_addr;
  logic        invalidate_all;
  logic [3:0]  Imem2proc_response;
  logic [63:0] Imem2proc_data;
  logic [3:0]  Imem2proc_tag;
  logic [1:0]  proc2Imem_command;
  logic [31:0] proc2Imem_addr;
  logic [63:0] Icache_data_out;
  logic        Icache_valid_out;
  logic        miss_busy;

  always #5 clock = ~clock;

  icache_sa #(
    .SETS(NS), .WAYS(NW), .ADDR_BITS(ICACHE_ADDR_BITS), .MEM_TAG_BITS(ICACHE_MEM_TAG_BITS)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .proc2Icache_addr   (proc2Icache_addr),
    .invalidate_all     (invalidate_all),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_data     (Imem2proc_data),
    .Imem2proc_tag      (Imem2proc_tag),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out),
    .miss_busy          (miss_busy)
  );

  typedef enum int {M_IDLE, M_REQ, M_WAIT} mode_e;

  // Cache contents as the model sees them: per set, a list of ways plus a replacement pointer.
  bit                  mv [NS][NW];
  logic [TAG_BITS-1:0] mt [NS][NW];
  logic [63:0]         md [NS][NW];
  int                  rr [NS];
  mode_e               m_mode;
  logic [28:0]         m_line;
  logic [3:0]          m_ptag;
  bit                  m_drop;

  // Bus responder: at most one accepted load in flight.
  bit          bs_v;
  logic [3:0]  bs_tag;
  logic [28:0] bs_line;
  int          bs_due;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit hold_rst = 1'b0;

  function automatic logic [63:0] mem_of(input logic [28:0] line);
    return {32'hC0DE_0000 ^ 32'(line), ~32'(line)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      rr[s] = 0;
      for (int w = 0; w < NW; w++) mv[s][w] = 1'b0;
    end
    m_mode = M_IDLE;
    m_line = '0;
    m_ptag = '0;
    m_drop = 1'b0;
    bs_v   = 1'b0;
  endtask

  task automatic install(input logic [28:0] line, input logic [63:0] data);
    int s;
    int w;
    s = int'(line[INDEX_BITS-1:0]);
    w = -1;
    for (int i = 0; i < NW; i++) if (!mv[s][i] && w < 0) w = i;
    if (w < 0) begin
      w = rr[s];
      rr[s] = (rr[s] + 1) % NW;
    end
    mv[s][w] = 1'b1;
    mt[s][w] = line[INDEX_BITS +: TAG_BITS];
    md[s][w] = data;
  endtask

  // Compare every DUT output with the model, then advance the model across the coming edge.
  task automatic step();
    logic [28:0]         fl;
    logic [TAG_BITS-1:0] tg;
    int s;
    int hw;
    bit fill;
    bit byp;
    if (!reset_n) begin
      model_reset();
      chk("reset_command", 64'(proc2Imem_command), 64'(BUS_NONE));
      chk("reset_mem_addr", 64'(proc2Imem_addr), 64'd0);
      chk("reset_valid", 64'(Icache_valid_out), 64'd0);
      chk("reset_busy", 64'(miss_busy), 64'd0);
      return;
    end
    fl = proc2Icache_addr[31:3];
    s  = int'(fl[INDEX_BITS-1:0]);
    tg = fl[INDEX_BITS +: TAG_BITS];
    hw = -1;
    for (int w = 0; w < NW; w++) if (mv[s][w] && mt[s][w] == tg) hw = w;
    fill = (m_mode == M_WAIT) && (m_ptag != 4'd0) && (Imem2proc_tag == m_ptag);
    byp  = fill && (fl == m_line) && !m_drop;

    chk("valid_out", 64'(Icache_valid_out), 64'((hw >= 0) || byp));
    if (hw >= 0) chk("data_hit", Icache_data_out, md[s][hw]);
    else if (byp) chk("data_bypass", Icache_data_out, Imem2proc_data);
    chk("command", 64'(proc2Imem_command), 64'((m_mode == M_REQ) ? BUS_LOAD : BUS_NONE));
    chk("mem_addr", 64'(proc2Imem_addr), 64'({m_line, 3'b000}));
    chk("miss_busy", 64'(miss_busy), 64'(m_mode != M_IDLE));
    chk("single_hit", 64'($countones(dut.hit_w) <= 1), 64'd1);

    if (invalidate_all)
      for (int i = 0; i < NS; i++) for (int w = 0; w < NW; w++) mv[i][w] = 1'b0;
    case (m_mode)
      M_IDLE: if (hw < 0 && !invalidate_all) begin m_line = fl; m_mode = M_REQ; end
      M_REQ: begin
        if (Imem2proc_response != 4'd0) begin
          m_ptag = Imem2proc_response;
          m_drop = invalidate_all;
          m_mode = M_WAIT;
        end else if (invalidate_all || fl != m_line) begin
          m_mode = M_IDLE;
        end
      end
      default: begin
        if (fill) begin
          if (!m_drop && !invalidate_all) install(m_line, Imem2proc_data);
          m_drop = 1'b0;
          m_mode = M_IDLE;
        end else if (invalidate_all) begin
          m_drop = 1'b1;
        end
      end
    endcase
  endtask

  task automatic cycle(input logic [31:0] a, input logic inv, input logic [3:0] resp,
                       input logic [3:0] t, input logic [63:0] d);
    @(negedge clock);
    reset_n            = !hold_rst;
    proc2Icache_addr   = a;
    invalidate_all     = inv;
    Imem2proc_response = resp;
    Imem2proc_tag      = t;
    Imem2proc_data     = d;
    #1;
    step();
    cyc++;
  endtask

  task automatic do_reset();
    hold_rst = 1'b1;
    repeat (2) cycle(32'h0, 1'b0, 4'd0, 4'd0, 64'd0);
    hold_rst = 1'b0;
  endtask

  task automatic fill_line(input logic [31:0] a, input logic [3:0] t, input logic [63:0] d);
    cycle(a, 1'b0, 4'd0, 4'd0, 64'd0);
    cycle(a, 1'b0, t, 4'd0, 64'd0);
    cycle(a, 1'b0, 4'd0, t, d);
  endtask

  initial begin
    logic [31:0] addr;
    logic [3:0]  resp;
    logic [3:0]  tg;
    logic [63:0] dat;
    logic        inv;
    int          ln;

    reset_n = 1'b0;
    proc2Icache_addr = '0; invalidate_all = 1'b0;
    Imem2proc_response = '0; Imem2proc_tag = '0; Imem2proc_data = '0;
    model_reset();

    // Cold miss, immediate accept, bypass then array hit.
    do_reset();
    cycle(32'h100, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("cold_idle_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    cycle(32'h100, 1'b0, 4'd3, 4'd0, 64'd0);
    chk("cold_req_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
    chk("cold_req_addr", 64'(proc2Imem_addr), 64'h100);
    cycle(32'h100, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("cold_one_cycle_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    cycle(32'h100, 1'b0, 4'd0, 4'd3, 64'hDEAD_BEEF_0000_0001);
    chk("cold_bypass_valid", 64'(Icache_valid_out), 64'd1);
    chk("cold_bypass_data", Icache_data_out, 64'hDEAD_BEEF_0000_0001);
    cycle(32'h100, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("cold_array_hit", Icache_data_out, 64'hDEAD_BEEF_0000_0001);
    chk("cold_busy_clear", 64'(miss_busy), 64'd0);

    // Retry: three refusals, then accept with tag 5.
    cycle(32'h108, 1'b0, 4'd0, 4'd0, 64'd0);
    repeat (3) begin
      cycle(32'h108, 1'b0, 4'd0, 4'd0, 64'd0);
      chk("retry_cmd_held", 64'(proc2Imem_command), 64'(BUS_LOAD));
      chk("retry_addr_held", 64'(proc2Imem_addr), 64'h108);
    end
    cycle(32'h108, 1'b0, 4'd5, 4'd0, 64'd0);
    chk("retry_accept_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
    cycle(32'h108, 1'b0, 4'd0, 4'd0, 64'd0);
    cycle(32'h108, 1'b0, 4'd0, 4'd5, 64'h1111_2222_3333_4444);
    cycle(32'h108, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("retry_fill_hit", Icache_data_out, 64'h1111_2222_3333_4444);

    // Replacement in set 0: third line evicts way 0.
    do_reset();
    fill_line(32'h0000, 4'd1, 64'hA0);
    fill_line(32'h0080, 4'd2, 64'hB0);
    fill_line(32'h0100, 4'd3, 64'hC0);
    cycle(32'h0080, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("assoc_keep_valid", 64'(Icache_valid_out), 64'd1);
    chk("assoc_keep_data", Icache_data_out, 64'hB0);
    cycle(32'h0000, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("assoc_evicted", 64'(Icache_valid_out), 64'd0);
    cycle(32'h0100, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("abandon_req_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
    cycle(32'h0100, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("abandon_idle", 64'(miss_busy), 64'd0);
    chk("assoc_new_data", Icache_data_out, 64'hC0);

    // Redirect during WAIT: hits continue, fill still lands.
    do_reset();
    fill_line(32'h0000, 4'd1, 64'hA1);
    cycle(32'h0200, 1'b0, 4'd0, 4'd0, 64'd0);
    cycle(32'h0200, 1'b0, 4'd2, 4'd0, 64'd0);
    cycle(32'h0000, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("redirect_hit", Icache_data_out, 64'hA1);
    chk("redirect_busy", 64'(miss_busy), 64'd1);
    cycle(32'h0000, 1'b0, 4'd0, 4'd2, 64'hE2);
    chk("redirect_no_bypass", Icache_data_out, 64'hA1);
    cycle(32'h0200, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("redirect_fill_hit", Icache_data_out, 64'hE2);

    // Invalidate during WAIT: everything misses and the fill is dropped.
    do_reset();
    fill_line(32'h0008, 4'd1, 64'hA2);
    cycle(32'h0040, 1'b0, 4'd0, 4'd0, 64'd0);
    cycle(32'h0040, 1'b0, 4'd4, 4'd0, 64'd0);
    cycle(32'h0040, 1'b1, 4'd0, 4'd0, 64'd0);
    cycle(32'h0008, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("inv_all_miss", 64'(Icache_valid_out), 64'd0);
    cycle(32'h0040, 1'b0, 4'd0, 4'd4, 64'hF4);
    chk("inv_dropped_no_bypass", 64'(Icache_valid_out), 64'd0);
    cycle(32'h0040, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("inv_not_written", 64'(Icache_valid_out), 64'd0);
    cycle(32'h0040, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("inv_new_miss", 64'(proc2Imem_command), 64'(BUS_LOAD));

    // Asynchronous reset between edges while in REQ.
    do_reset();
    cycle(32'h0300, 1'b0, 4'd0, 4'd0, 64'd0);
    cycle(32'h0300, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("arst_pre_cmd", 64'(proc2Imem_command), 64'(BUS_LOAD));
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_cmd_now", 64'(proc2Imem_command), 64'(BUS_NONE));
    chk("arst_busy_now", 64'(miss_busy), 64'd0);
    model_reset();
    hold_rst = 1'b1;
    cycle(32'h0300, 1'b0, 4'd0, 4'd0, 64'd0);
    hold_rst = 1'b0;
    cycle(32'h0300, 1'b0, 4'd0, 4'd0, 64'd0);
    chk("arst_no_write", 64'(Icache_valid_out), 64'd0);

    // Randomized traffic.
    do_reset();
    addr = 32'h0;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 9) < 3) begin
        ln   = ($urandom_range(0, 5) << 4) | $urandom_range(0, 2);
        addr = (32'(ln) << 3) | 32'($urandom_range(0, 7));
      end
      inv  = ($urandom_range(0, 49) == 0);
      resp = 4'd0;
      if (m_mode == M_REQ && !bs_v && $urandom_range(0, 1) == 1) begin
        resp    = 4'($urandom_range(1, 15));
        bs_v    = 1'b1;
        bs_tag  = resp;
        bs_line = m_line;
        bs_due  = cyc + int'($urandom_range(1, 4));
      end
      if (bs_v && cyc >= bs_due && m_mode == M_WAIT) begin
        tg   = bs_tag;
        dat  = mem_of(bs_line);
        bs_v = 1'b0;
      end else begin
        tg  = 4'($urandom_range(0, 15));
        if (m_mode == M_WAIT && tg == m_ptag) tg = 4'd0;
        dat = {$urandom, $urandom};
      end
      cycle(addr, inv, resp, tg, dat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
